mux_scan_sequencer: RTL

//  Upstream control stage for the 8-input multiplexer. Drives its chip select
//  (cs1) and select lines (se1 MSB, se2, se3 LSB) through channels 0..7 in turn.

---
 rtl/mux_scan_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps an 8:1 mux through channels 0..7 and packs the samples into a byte
`timescale 1ns/1ps

module mux_scan_sequencer #(
  parameter int unsigned SETTLE     = 2,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_out,
  output logic       cs1,
  output logic       se1,
  output logic       se2,
  output logic       se3,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state, state_nx;
  logic [2:0] ch, ch_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic [7:0] data_nx;
  logic       valid_nx;
  logic       cs1_nx;
  logic [2:0] sel, sel_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch    <= 3'd0;
      cnt   <= 4'd0;
      shreg <= 8'h00;
      data  <= 8'h00;
      valid <= 1'b0;
      cs1   <= 1'b0;
      sel   <= 3'd0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
      data  <= data_nx;
      valid <= valid_nx;
      cs1   <= cs1_nx;
      sel   <= sel_nx;
    end
  end

  // cs1 and the selects are registered alongside ch so they stay glitch-free for the whole channel.
  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    data_nx  = data;
    valid_nx = valid;
    cs1_nx   = cs1;
    sel_nx   = sel;

    case (state)
      IDLE: begin
        if (start || CONTINUOUS) begin
          state_nx = SCAN;
          ch_nx    = 3'd0;
          cnt_nx   = SETTLE_CNT;
          cs1_nx   = 1'b1;
          sel_nx   = 3'd0;
        end
      end

      SCAN: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          shreg_nx[ch] = mux_out;
          if (ch != 3'd7) begin
            ch_nx  = ch + 3'd1;
            cnt_nx = SETTLE_CNT;
            sel_nx = ch + 3'd1;
          end else begin
            // Last channel: the byte published must include this cycle's sample.
            data_nx  = shreg_nx;
            valid_nx = 1'b1;
            cs1_nx   = 1'b0;
            sel_nx   = 3'd0;
            ch_nx    = 3'd0;
            state_nx = HOLD;
          end
        end
      end

      HOLD: begin
        if (ready) begin
          valid_nx = 1'b0;
          if (start || CONTINUOUS) begin
            state_nx = SCAN;
            ch_nx    = 3'd0;
            cnt_nx   = SETTLE_CNT;
            cs1_nx   = 1'b1;
            sel_nx   = 3'd0;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        cs1_nx   = 1'b0;
        sel_nx   = 3'd0;
      end
    endcase
  end

  assign {se1, se2, se3} = sel;
  assign busy            = (state != IDLE);

endmodule
